// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory bus between the data (load/store) requester on port 0 and
// the sequencer fetch requester on port 1. A granted request is registered onto
// the memory bus and held there until the memory answers. The response is then
// returned to the winning port with a single-cycle ready pulse. A watchdog
// forces completion of a memory transaction that never answers.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to give simultaneous requests
// to the port that did not win the previous grant. When it is undefined, port 0
// always wins a tie.
//
// Parameters
//   TIMEOUT_CYCLES  memory wait cycles before forced completion (2..65535)
//   TIMEOUT_DATA    read data returned on a timed-out transaction
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   d_*                    port 0 (data requester): valid, instr, addr,
//                          write_data, wstrb in; ready, read_data out
//   i_*                    port 1 (fetch requester): same fields as d_*
//   mem_*                  shared memory bus: valid, instr, addr, write_data,
//                          wstrb out; ready, read_data in
//   grant_o                one-hot owner of the current transaction, 0 if idle
//   busy_o                 high whenever the FSM is not idle
//   timeout_o              sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // port 0: data requester
  input  logic        d_valid,
  input  logic        d_instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_read_data,
  // port 1: fetch requester
  input  logic        i_valid,
  input  logic        i_instr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_wstrb,
  output logic        i_ready,
  output logic [31:0] i_read_data,
  // shared memory bus
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data,
  // status
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Last counter value that is still allowed to wait for memory.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        owner;      // 0: port 0 owns the bus, 1: port 1
  logic        lock_d;
  logic        lock_i;
  logic [15:0] wait_cnt;

  logic        elig_d;
  logic        elig_i;
  logic        any_elig;
  logic        win;        // 0: port 0 wins, 1: port 1 wins

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign elig_d   = d_valid && !lock_d;
  assign elig_i   = i_valid && !lock_i;
  assign any_elig = elig_d || elig_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_prio names the port that gets a tie: the loser of the previous grant.
  logic rr_prio;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_prio <= 1'b0;
    end else if (state == S_IDLE && any_elig) begin
      rr_prio <= ~win;
    end
  end

  assign win = (elig_d && elig_i) ? rr_prio : !elig_d;
`else
  assign win = !elig_d;
`endif

  // The ready pulse is simply the RESP state decoded for the owning port, so a
  // reset (which forces IDLE) can never leave a stray pulse behind.
  assign d_ready = (state == S_RESP) && !owner;
  assign i_ready = (state == S_RESP) &&  owner;
  assign busy_o  = (state != S_IDLE);

  // Control and response path
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      lock_d      <= 1'b0;
      lock_i      <= 1'b0;
      wait_cnt    <= 16'd0;
      grant_o     <= 2'b00;
      timeout_o   <= 1'b0;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wstrb   <= 4'd0;
      d_read_data <= 32'd0;
      i_read_data <= 32'd0;
    end else begin
      // Lockout lasts exactly the one IDLE cycle following a ready pulse.
      lock_d <= 1'b0;
      lock_i <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            owner     <= win;
            grant_o   <= win ? 2'b10 : 2'b01;
            mem_valid <= 1'b1;
            mem_instr <= win ? i_instr : d_instr;
            mem_addr  <= win ? i_addr  : d_addr;
            mem_wstrb <= win ? i_wstrb : d_wstrb;
            wait_cnt  <= 16'd0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (owner) i_read_data <= mem_read_data;
            else       d_read_data <= mem_read_data;
            mem_valid <= 1'b0;
            state     <= S_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            if (owner) i_read_data <= TIMEOUT_DATA;
            else       d_read_data <= TIMEOUT_DATA;
            timeout_o <= 1'b1;
            mem_valid <= 1'b0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        S_RESP: begin
          if (owner) lock_i <= 1'b1;
          else       lock_d <= 1'b1;
          grant_o <= 2'b00;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data carries no reset; it is only meaningful while mem_valid is set.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && any_elig) begin
      mem_write_data <= win ? i_write_data : d_write_data;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        d_valid, d_instr, d_ready;
  logic [31:0] d_addr, d_write_data, d_read_data;
  logic [3:0]  d_wstrb;
  logic        i_valid, i_instr, i_ready;
  logic [31:0] i_addr, i_write_data, i_read_data;
  logic [3:0]  i_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant_o;
  logic        busy_o, timeout_o;

  int n_chk = 0;
  int n_bad = 0;

  // Grant expected when both ports become eligible at once with no lockout
  // pending: fixed priority always picks port 0, round robin picks the loser
  // of the previous grant (port 1 in both places this is used below).
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] TIE_FIRST  = 2'b10;
  localparam logic [1:0] TIE_SECOND = 2'b01;
`else
  localparam logic [1:0] TIE_FIRST  = 2'b01;
  localparam logic [1:0] TIE_SECOND = 2'b10;
`endif

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .d_valid        (d_valid),
    .d_instr        (d_instr),
    .d_addr         (d_addr),
    .d_write_data   (d_write_data),
    .d_wstrb        (d_wstrb),
    .d_ready        (d_ready),
    .d_read_data    (d_read_data),
    .i_valid        (i_valid),
    .i_instr        (i_instr),
    .i_addr         (i_addr),
    .i_write_data   (i_write_data),
    .i_wstrb        (i_wstrb),
    .i_ready        (i_ready),
    .i_read_data    (i_read_data),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_read_data  (mem_read_data),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    d_valid = 1'b1; d_instr = 1'b0; d_addr = 32'h0; d_write_data = 32'h0; d_wstrb = 4'h0;
    i_valid = 1'b1; i_instr = 1'b1; i_addr = 32'h0; i_write_data = 32'h0; i_wstrb = 4'h0;
    mem_ready = 1'b0; mem_read_data = 32'h0;

    // Reset with both ports requesting
    tick(); tick();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_d_rdata", d_read_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    d_valid = 1'b0; i_valid = 1'b0;
    rst_ni = 1'b1;
    tick();

    // Fetch read at 0x10, memory answers in the first WAIT cycle
    i_valid = 1'b1; i_instr = 1'b1; i_addr = 32'h10;
    mem_ready = 1'b1; mem_read_data = 32'hA5A5_0001;
    tick();
    chk("rd_mem_valid", mem_valid, 1);
    chk("rd_grant", grant_o, 2'b10);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_instr", mem_instr, 1);
    chk("rd_i_ready_early", i_ready, 0);
    tick();
    chk("rd_i_ready", i_ready, 1);
    chk("rd_i_rdata", i_read_data, 32'hA5A5_0001);
    chk("rd_grant_resp", grant_o, 2'b10);
    chk("rd_d_ready", d_ready, 0);
    chk("rd_mem_valid_drop", mem_valid, 0);
    tick();
    chk("rd_i_ready_once", i_ready, 0);
    chk("rd_grant_clr", grant_o, 0);
    i_addr = 32'h14;                     // change address during lockout
    mem_read_data = 32'hA5A5_0002;
    tick();
    chk("lock_no_dup", mem_valid, 0);
    chk("lock_idle", busy_o, 0);
    tick();
    chk("rd2_mem_valid", mem_valid, 1);
    chk("rd2_mem_addr", mem_addr, 32'h14);
    tick();
    chk("rd2_i_ready", i_ready, 1);
    chk("rd2_i_rdata", i_read_data, 32'hA5A5_0002);
    i_valid = 1'b0; mem_ready = 1'b0;
    tick();
    tick();

    // Data write, memory waits one cycle; request must stay stable
    d_valid = 1'b1; d_instr = 1'b0; d_addr = 32'h40;
    d_write_data = 32'h1234_5678; d_wstrb = 4'b0011;
    tick();
    chk("wr_grant", grant_o, 2'b01);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_write_data, 32'h1234_5678);
    chk("wr_mem_wstrb", mem_wstrb, 4'b0011);
    chk("wr_mem_instr", mem_instr, 0);
    tick();
    chk("wr_hold_valid", mem_valid, 1);
    chk("wr_hold_addr", mem_addr, 32'h40);
    chk("wr_hold_wdata", mem_write_data, 32'h1234_5678);
    chk("wr_hold_wstrb", mem_wstrb, 4'b0011);
    chk("wr_d_ready_wait", d_ready, 0);
    mem_ready = 1'b1; mem_read_data = 32'hCAFE_0000;
    tick();
    chk("wr_d_ready", d_ready, 1);
    chk("wr_d_rdata", d_read_data, 32'hCAFE_0000);
    chk("wr_loser_hold", i_read_data, 32'hA5A5_0002);
    chk("wr_loser_ready", i_ready, 0);
    d_valid = 1'b0;
    tick();
    tick();

    // Tie after a port-0 grant with no lockout pending
    d_valid = 1'b1; i_valid = 1'b1; d_addr = 32'h50; i_addr = 32'h60;
    mem_read_data = 32'h1111_1111;
    tick();
    chk("tie1_grant", grant_o, TIE_FIRST);
    tick();                              // RESP
    tick();                              // IDLE, winner locked
    tick();
    chk("tie1_other", grant_o, TIE_SECOND);
    tick();                              // RESP
    tick();                              // IDLE, winner locked
    d_valid = 1'b0; i_valid = 1'b0;
    tick();
    // Fresh tie: fixed gives port 0, round robin gives port 1 (last grant d)
    d_valid = 1'b1; i_valid = 1'b1;
    tick();
    chk("tie2_grant", grant_o, TIE_FIRST);
    d_valid = 1'b0; i_valid = 1'b0;
    tick();
    tick();
    tick();

    // Watchdog: memory never answers, TIMEOUT_CYCLES = 4
    mem_ready = 1'b0;
    d_valid = 1'b1; d_addr = 32'h80;
    tick();
    chk("to_mem_valid", mem_valid, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_wait_ready", d_ready, 0);
      chk("to_wait_flag", timeout_o, 0);
    end
    tick();
    chk("to_d_ready", d_ready, 1);
    chk("to_d_rdata", d_read_data, 32'hDEAD_BEEF);
    chk("to_flag", timeout_o, 1);
    chk("to_mem_valid_drop", mem_valid, 0);
    d_valid = 1'b0;
    tick();
    tick();
    chk("to_sticky", timeout_o, 1);
    chk("to_ready_once", d_ready, 0);

    // Reset during WAIT, memory answers afterwards
    d_valid = 1'b1; d_addr = 32'h90;
    tick();
    chk("rw_busy", busy_o, 1);
    rst_ni = 1'b0; d_valid = 1'b0;
    tick();
    chk("rw_mem_valid", mem_valid, 0);
    chk("rw_grant", grant_o, 0);
    chk("rw_busy_clr", busy_o, 0);
    chk("rw_timeout_clr", timeout_o, 0);
    rst_ni = 1'b1; mem_ready = 1'b1;
    tick();
    chk("rw_d_ready", d_ready, 0);
    chk("rw_i_ready", i_ready, 0);
    tick();
    chk("rw_d_ready2", d_ready, 0);
    chk("rw_idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
